t_table: RTL

T_TABLE -- requirements
Module: t_table

---
 rtl/t_table.sv | 106 ++++++++++
 1 files changed

// File: rtl/t_table.sv
// rtl/t_table.sv - three-bank prefix-sum table builder with a two-stage registered read port
// Bank nu holds the saturating running sum of in<nu>; entries fill in order while in BUILD.
module t_table #(
  parameter int BIT_WIDTH = 32,
  parameter int I = 160,
  parameter int NU_VALUES = 3,
  localparam int AW = $clog2(I)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic                 in_valid,
  input  logic [BIT_WIDTH-1:0] in0,
  input  logic [BIT_WIDTH-1:0] in1,
  input  logic [BIT_WIDTH-1:0] in2,
  output logic                 table_ready,
  output logic [AW:0]          count_out,
  output logic                 overflow_err,
  input  logic [AW-1:0]        T_req,
  output logic [BIT_WIDTH-1:0] T_resp0,
  output logic [BIT_WIDTH-1:0] T_resp1,
  output logic [BIT_WIDTH-1:0] T_resp2
);

  typedef enum logic [1:0] {IDLE, BUILD, READY} state_t;

  state_t state;

  logic [2:0][BIT_WIDTH-1:0]           x;
  logic [NU_VALUES-1:0][BIT_WIDTH-1:0] acc;
  logic [NU_VALUES-1:0][BIT_WIDTH-1:0] acc_nxt;
  logic [NU_VALUES-1:0][BIT_WIDTH-1:0] resp;
  logic [NU_VALUES-1:0]                sat;
  logic                                wr_en;
  logic                                last_wr;
  logic                                in_range;

  assign x        = {in2, in1, in0};
  assign wr_en    = in_valid && !start_in && (state == BUILD);
  assign last_wr  = (count_out == (AW+1)'(I - 1));
  assign in_range = ({1'b0, T_req} < (AW+1)'(I));

  for (genvar g = 0; g < NU_VALUES; g++) begin : g_bank
    logic [BIT_WIDTH:0]   wide;
    logic [BIT_WIDTH-1:0] mem [I];
    logic [BIT_WIDTH-1:0] rd_q;
    logic [BIT_WIDTH-1:0] resp_q;

    // Sign-extended add: the two top bits disagree exactly when the signed sum overflowed.
    assign wide       = {acc[g][BIT_WIDTH-1], acc[g]} + {x[g][BIT_WIDTH-1], x[g]};
    assign sat[g]     = wide[BIT_WIDTH] ^ wide[BIT_WIDTH-1];
    assign acc_nxt[g] = !sat[g]          ? wide[BIT_WIDTH-1:0] :
                        wide[BIT_WIDTH]  ? {1'b1, {(BIT_WIDTH-1){1'b0}}} :
                                           {1'b0, {(BIT_WIDTH-1){1'b1}}};

    always_ff @(posedge clk_in) begin
      if (wr_en) mem[count_out[AW-1:0]] <= acc_nxt[g];
    end

    // Array read and write share an edge, so a colliding read sees the old word.
    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        rd_q   <= '0;
        resp_q <= '0;
      end else begin
        rd_q   <= in_range ? mem[T_req] : '0;
        resp_q <= rd_q;
      end
    end

    assign resp[g] = resp_q;
  end

  assign T_resp0 = resp[0];
  assign T_resp1 = resp[1];
  assign T_resp2 = resp[2];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state        <= IDLE;
      count_out    <= '0;
      table_ready  <= 1'b0;
      overflow_err <= 1'b0;
      acc          <= '0;
    end else if (start_in) begin
      state        <= BUILD;
      count_out    <= '0;
      table_ready  <= 1'b0;
      overflow_err <= 1'b0;
      acc          <= '0;
    end else if (in_valid) begin
      if (state == BUILD) begin
        acc       <= acc_nxt;
        count_out <= count_out + 1'b1;
        if (|sat) overflow_err <= 1'b1;
        if (last_wr) begin
          state       <= READY;
          table_ready <= 1'b1;
        end
      end else begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule
